// File: rtl/dct_block_serializer_if.sv
// -----------------------------------------------------------------------------
// dct_block_serializer_if
// Handshake bundle around the 8x8 block serializer.
//   in_valid  : upstream column word valid
//   in_ready  : serializer accepts a column this cycle
//   in_data   : packed [7:0][W-1:0], lane k = row k of the current column
//   out_valid : out_data/out_idx valid
//   out_ready : consumer accepts the coefficient this cycle
//   out_data  : coefficient (W bits, two's complement, unmodified)
//   out_idx   : output sequence number 0..63
//   out_last  : high with out_valid on sequence number 63
//   blk_done  : one-cycle pulse after the 64th coefficient is accepted
// Modports: slave = the serializer itself, master = the environment around it.
// -----------------------------------------------------------------------------
interface dct_block_serializer_if #(
  parameter int W = 12
);
  logic                in_valid;
  logic                in_ready;
  logic [7:0][W-1:0]   in_data;
  logic                out_valid;
  logic                out_ready;
  logic [W-1:0]        out_data;
  logic [5:0]          out_idx;
  logic                out_last;
  logic                blk_done;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_idx, out_last, blk_done
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_idx, out_last, blk_done
  );
endinterface

// File: rtl/dct_block_serializer.sv
// -----------------------------------------------------------------------------
// dct_block_serializer
// Buffers one 8x8 block of W-bit coefficients delivered column by column, then
// emits the 64 coefficients one per handshake in JPEG zigzag order (ZIGZAG=1)
// or row-major order (ZIGZAG=0). Fill and drain never overlap.
// Ports:
//   clk : clock
//   rst : synchronous, active-high reset (buffer contents are kept)
//   bus : dct_block_serializer_if.slave carrying the column input handshake,
//         the coefficient output handshake and the blk_done pulse
// -----------------------------------------------------------------------------
module dct_block_serializer #(
  parameter int W      = 12,
  parameter int ZIGZAG = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  dct_block_serializer_if.slave   bus
);

  typedef enum logic [0:0] {
    FILL  = 1'b0,
    DRAIN = 1'b1
  } state_e;

  state_e       state_q, state_d;
  logic [2:0]   col_cnt_q, col_cnt_d;
  logic [5:0]   pos_q, pos_d;
  logic         blk_done_q, blk_done_d;
  logic [W-1:0] mem_q [8][8];

  logic         in_fire_s;
  logic         out_fire_s;
  logic [5:0]   nat_s;

  // Zigzag sequence number -> natural index {row, col} of the 8x8 block.
  function automatic logic [5:0] zz_nat(input logic [5:0] p);
    logic [5:0] n;
    case (p)
      6'd0:  n = 6'd0;   6'd1:  n = 6'd1;   6'd2:  n = 6'd8;   6'd3:  n = 6'd16;
      6'd4:  n = 6'd9;   6'd5:  n = 6'd2;   6'd6:  n = 6'd3;   6'd7:  n = 6'd10;
      6'd8:  n = 6'd17;  6'd9:  n = 6'd24;  6'd10: n = 6'd32;  6'd11: n = 6'd25;
      6'd12: n = 6'd18;  6'd13: n = 6'd11;  6'd14: n = 6'd4;   6'd15: n = 6'd5;
      6'd16: n = 6'd12;  6'd17: n = 6'd19;  6'd18: n = 6'd26;  6'd19: n = 6'd33;
      6'd20: n = 6'd40;  6'd21: n = 6'd48;  6'd22: n = 6'd41;  6'd23: n = 6'd34;
      6'd24: n = 6'd27;  6'd25: n = 6'd20;  6'd26: n = 6'd13;  6'd27: n = 6'd6;
      6'd28: n = 6'd7;   6'd29: n = 6'd14;  6'd30: n = 6'd21;  6'd31: n = 6'd28;
      6'd32: n = 6'd35;  6'd33: n = 6'd42;  6'd34: n = 6'd49;  6'd35: n = 6'd56;
      6'd36: n = 6'd57;  6'd37: n = 6'd50;  6'd38: n = 6'd43;  6'd39: n = 6'd36;
      6'd40: n = 6'd29;  6'd41: n = 6'd22;  6'd42: n = 6'd15;  6'd43: n = 6'd23;
      6'd44: n = 6'd30;  6'd45: n = 6'd37;  6'd46: n = 6'd44;  6'd47: n = 6'd51;
      6'd48: n = 6'd58;  6'd49: n = 6'd59;  6'd50: n = 6'd52;  6'd51: n = 6'd45;
      6'd52: n = 6'd38;  6'd53: n = 6'd31;  6'd54: n = 6'd39;  6'd55: n = 6'd46;
      6'd56: n = 6'd53;  6'd57: n = 6'd60;  6'd58: n = 6'd61;  6'd59: n = 6'd54;
      6'd60: n = 6'd47;  6'd61: n = 6'd55;  6'd62: n = 6'd62;  6'd63: n = 6'd63;
      default: n = 6'd63;
    endcase
    return n;
  endfunction

  // Handshakes qualify only on state, so ready/valid never depend on the peer.
  assign in_fire_s  = bus.in_valid  && (state_q == FILL);
  assign out_fire_s = bus.out_ready && (state_q == DRAIN);

  // Next-state logic: column counting during fill, sequence stepping during drain.
  always_comb begin
    state_d    = state_q;
    col_cnt_d  = col_cnt_q;
    pos_d      = pos_q;
    blk_done_d = 1'b0;
    case (state_q)
      FILL: begin
        if (in_fire_s) begin
          // 3-bit counter wraps 7 -> 0 on the last column by itself.
          col_cnt_d = col_cnt_q + 3'd1;
          if (col_cnt_q == 3'd7) begin
            state_d = DRAIN;
          end else begin
            state_d = FILL;
          end
        end else begin
          col_cnt_d = col_cnt_q;
        end
      end
      DRAIN: begin
        if (out_fire_s) begin
          pos_d = pos_q + 6'd1;
          if (pos_q == 6'd63) begin
            state_d    = FILL;
            blk_done_d = 1'b1;
          end else begin
            state_d = DRAIN;
          end
        end else begin
          pos_d = pos_q;
        end
      end
      default: begin
        state_d   = FILL;
        col_cnt_d = 3'd0;
        pos_d     = 6'd0;
      end
    endcase
  end

  // Control state registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= FILL;
      col_cnt_q  <= 3'd0;
      pos_q      <= 6'd0;
      blk_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      col_cnt_q  <= col_cnt_d;
      pos_q      <= pos_d;
      blk_done_q <= blk_done_d;
    end
  end

  // Block buffer: each accepted column scatters its 8 lanes down one column.
  always_ff @(posedge clk) begin
    if (in_fire_s) begin
      for (int k = 0; k < 8; k++) begin
        mem_q[k][col_cnt_q] <= bus.in_data[k];
      end
    end
  end

  assign nat_s = (ZIGZAG != 0) ? zz_nat(pos_q) : pos_q;

  assign bus.in_ready  = (state_q == FILL);
  assign bus.out_valid = (state_q == DRAIN);
  assign bus.out_data  = mem_q[nat_s[5:3]][nat_s[2:0]];
  assign bus.out_idx   = pos_q;
  assign bus.out_last  = (state_q == DRAIN) && (pos_q == 6'd63);
  assign bus.blk_done  = blk_done_q;

endmodule

// File: doc/dct_block_serializer.md
Name: dct_block_serializer

Overview:
Reader end of the 8x8 transpose path in the JPEG accelerator. Accepts one 8-coefficient column per handshake from the second 1-D DCT pass and buffers a full 8x8 block (12-bit coefficients). Then emits the 64 coefficients one per handshake, in JPEG zigzag order or row-major order, to the quantiser/Wishbone output stage. Single buffer: fill and drain phases do not overlap.

Parameters:
W, 12, coefficient width in bits (two's complement, passed through unmodified)
ZIGZAG, 1, 1 = emit in JPEG zigzag order; 0 = emit row-major (row 0 col 0..7, then row 1, ...)

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
in_valid  in  1  column word valid
in_ready  out  1  block accepts a column this cycle
in_data  in  8xW  packed [7:0][W-1:0]; in_data[k] = coefficient at row k of the current column
out_valid  out  1  out_data/out_idx valid
out_ready  in  1  consumer accepts coefficient this cycle
out_data  out  W  coefficient
out_idx  out  6  output sequence number 0..63 (zigzag index when ZIGZAG=1)
out_last  out  1  high together with out_valid when out_idx==63
blk_done  out  1  one-cycle pulse in the cycle after the 64th coefficient is accepted

Behaviour:
- States: FILL, DRAIN. Registers: col_cnt (3 bits), pos (6 bits), mem[8][8] of W bits.
- Reset (registered on clk while rst=1): state=FILL, col_cnt=0, pos=0, blk_done=0. Buffer contents are not cleared. Outputs after reset: in_ready=1, out_valid=0, out_last=0, blk_done=0; out_idx=0. out_data is don't-care while out_valid=0.
- in_ready = (state==FILL); out_valid = (state==DRAIN). Both are pure state decodes with no combinational path from in_valid or out_ready.
- FILL: on in_valid&&in_ready, write mem[k][col_cnt] <= in_data[k] for k=0..7, and col_cnt++. The first accepted column is column 0. On the accept with col_cnt==7: col_cnt wraps to 0 and state becomes DRAIN.
- Latency: out_valid is high in the cycle immediately after the 8th column handshake.
- DRAIN: (r,c) = map(pos). ZIGZAG=1 uses the JPEG zigzag table: pos 0..9 -> (0,0)(0,1)(1,0)(2,0)(1,1)(0,2)(0,3)(1,2)(2,1)(3,0) ... pos 63 -> (7,7). The table is a 64-entry constant ROM. ZIGZAG=0 uses r=pos[5:3], c=pos[2:0].
- out_data = mem[r][c] (combinational mux from registers). out_idx = pos. out_last = (pos==63).
- On out_valid&&out_ready: pos++. If pos==63: pos wraps to 0, state becomes FILL, and blk_done=1 for the next cycle only.
- Backpressure: while out_valid&&!out_ready, out_data/out_idx/out_last hold stable and pos does not advance.
- in_valid during DRAIN is ignored (in_ready=0). No data is stored and col_cnt is unchanged.
- out_ready during FILL has no effect.
- Back-to-back blocks: a column may be accepted in the first cycle after the last output handshake (the cycle where blk_done=1). Minimum block period is 8 + 64 = 72 cycles.
- Reset in any state (mid-fill or mid-drain) aborts the block. The next column accepted after reset is column 0.
- No arithmetic on data. Values are copied bit-exact, with no sign extension or saturation.

Test Plan:
- Row-major load, ZIGZAG=1: send 8 columns with in_data[k] = k*8+c and in_valid held high, out_ready=1. Required: first out_valid one cycle after the 8th accept. out_data sequence 0,1,8,16,9,2,3,10,17,24,... ending 63 with out_last=1. out_idx counts 0..63. blk_done pulses once, then in_ready=1.
- ZIGZAG=0 with the same block: out_data = 0,1,2,...,63 in order. out_last is high only on 63.
- Backpressure: toggle out_ready 1,0,0,1,... and insert random in_valid gaps during fill. Required: no coefficient is lost or duplicated, out_data is stable during stalls, and the output sequence matches the first scenario.
- Signed passthrough: fill the block with 12'h800 at (0,0), 12'h7FF at (7,7) and 12'hFFF elsewhere. Required: pos 0 = 12'h800, pos 63 = 12'h7FF, all others 12'hFFF.
- in_valid during DRAIN: hold in_valid=1 with data 12'hAAA on all lanes through the drain. Required: in_ready=0 and the outputs still come from the original block. The next block's column 0 is accepted the cycle after the final output handshake, and that block drains correctly.
- Reset mid-operation: assert rst after 3 columns, then again at pos=20 of a drain. Required: in_ready=1 and out_valid=0 on the cycle after reset. A fresh 8-column block drains completely and correctly.
